// File: rtl/regfile_wr_ctrl_if.sv
// Bundle between the write-back/decode stages and the register-file write controller.
// master = requester (write-back stage and decode read ports), slave = regfile_wr_ctrl.
interface regfile_wr_ctrl_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              rd_valid;
  logic              clr_req;
  logic              busy;
  logic              wr_drop;
  logic [15:0]       wr_count;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr_a, rd_addr_b, clr_req,
    input  rd_data_a, rd_data_b, rd_valid, busy, wr_drop, wr_count
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr_a, rd_addr_b, clr_req,
    output rd_data_a, rd_data_b, rd_valid, busy, wr_drop, wr_count
  );
endinterface

// File: rtl/regfile_wr_ctrl.sv
// Register-file write controller: storage, R0-hardwired-zero write path, two registered
// read ports and a sequential clear engine. Define REGFILE_WR_BYPASS_EN for write-first reads.
module regfile_wr_ctrl #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 5,
  parameter int CLR_START = 1
) (
  input logic               clk,
  input logic               rst_n,
  regfile_wr_ctrl_if.slave  bus
);

  localparam int              DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-1:0] FIRST_CLR = ADDR_W'(CLR_START);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [ADDR_W-1:0]   r_clr_ptr;
  logic [DATA_W-1:0]   r_rd_a;
  logic [DATA_W-1:0]   r_rd_b;
  logic                r_rd_valid;
  logic                r_wr_drop;
  logic [15:0]         r_wr_count;

  logic                w_idle;
  logic                w_commit;
  logic                w_drop;
  logic                w_read;
  logic                w_byp_a;
  logic                w_byp_b;
  logic [DATA_W-1:0]   w_rd_a;
  logic [DATA_W-1:0]   w_rd_b;

  assign w_idle   = (r_state == S_IDLE);
  assign w_commit = w_idle && bus.wr_en && (bus.wr_addr != '0);
  assign w_drop   = w_idle && bus.wr_en && (bus.wr_addr == '0);
  assign w_read   = w_idle && bus.rd_en;

`ifdef REGFILE_WR_BYPASS_EN
  assign w_byp_a = w_commit && (bus.rd_addr_a == bus.wr_addr);
  assign w_byp_b = w_commit && (bus.rd_addr_b == bus.wr_addr);
`else
  assign w_byp_a = 1'b0;
  assign w_byp_b = 1'b0;
`endif

  // NOTE: always_comb assigns every output a default first so no path infers a latch.
  always_comb begin
    w_rd_a = (bus.rd_addr_a == '0) ? '0 : r_mem[bus.rd_addr_a];
    w_rd_b = (bus.rd_addr_b == '0) ? '0 : r_mem[bus.rd_addr_b];
    if (w_byp_a) w_rd_a = bus.wr_data;
    if (w_byp_b) w_rd_b = bus.wr_data;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (bus.clr_req) w_next_state = S_CLEAR;
      S_CLEAR: if (r_clr_ptr == LAST_ADDR) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: storage is reset because a reset must leave every register reading 0; this makes
  // it a flop array rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (r_state == S_CLEAR) begin
      r_mem[r_clr_ptr] <= '0;
    end else if (w_commit) begin
      r_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clr_ptr  <= '0;
      r_rd_a     <= '0;
      r_rd_b     <= '0;
      r_rd_valid <= 1'b0;
      r_wr_drop  <= 1'b0;
      r_wr_count <= '0;
    end else begin
      if (w_idle && bus.clr_req)  r_clr_ptr <= FIRST_CLR;
      else if (r_state == S_CLEAR) r_clr_ptr <= r_clr_ptr + 1'b1;
      if (w_read) begin
        r_rd_a <= w_rd_a;
        r_rd_b <= w_rd_b;
      end
      r_rd_valid <= w_read;
      r_wr_drop  <= w_drop;
      if (w_commit) r_wr_count <= r_wr_count + 16'd1;
    end
  end

  assign bus.rd_data_a = r_rd_a;
  assign bus.rd_data_b = r_rd_b;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.busy      = !w_idle;
  assign bus.wr_drop   = r_wr_drop;
  assign bus.wr_count  = r_wr_count;

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// Directed self-checking bench for regfile_wr_ctrl; honours REGFILE_WR_BYPASS_EN when defined.
module tb_regfile_wr_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  regfile_wr_ctrl_if bus_if ();

  regfile_wr_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] addr, input logic [63:0] data);
    bus_if.wr_en   = 1'b1;
    bus_if.wr_addr = addr;
    bus_if.wr_data = data;
    tick();
    bus_if.wr_en   = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] addr_a, input logic [4:0] addr_b);
    bus_if.rd_en     = 1'b1;
    bus_if.rd_addr_a = addr_a;
    bus_if.rd_addr_b = addr_b;
    tick();
    bus_if.rd_en     = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++; if (bus_if.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b want 0", bus_if.busy); end
    total++; if (bus_if.rd_valid !== 1'b0) begin bad++; $display("FAIL rst_rd_valid: got %0b want 0", bus_if.rd_valid); end
    total++; if (bus_if.wr_drop !== 1'b0) begin bad++; $display("FAIL rst_wr_drop: got %0b want 0", bus_if.wr_drop); end
    total++; if (bus_if.rd_data_a !== 64'd0) begin bad++; $display("FAIL rst_rd_a: got %h want 0", bus_if.rd_data_a); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    do_read(5'd3, 5'd0);
    total++; if (bus_if.rd_valid !== 1'b1) begin bad++; $display("FAIL rst_read_valid: got %0b want 1", bus_if.rd_valid); end
    total++; if (bus_if.rd_data_a !== 64'd0) begin bad++; $display("FAIL rst_read_a: got %h want 0", bus_if.rd_data_a); end
    total++; if (bus_if.rd_data_b !== 64'd0) begin bad++; $display("FAIL rst_read_b: got %h want 0", bus_if.rd_data_b); end
    total++; if (bus_if.wr_count !== 16'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", bus_if.wr_count); end
  endtask

  task automatic test_write();
    do_write(5'd5, 64'hDEADBEEF_00000001);
    do_read(5'd5, 5'd5);
    total++; if (bus_if.rd_data_a !== 64'hDEADBEEF_00000001) begin bad++; $display("FAIL wr_read_a: got %h want deadbeef00000001", bus_if.rd_data_a); end
    total++; if (bus_if.wr_count !== 16'd1) begin bad++; $display("FAIL wr_count: got %0d want 1", bus_if.wr_count); end
    bus_if.rd_addr_a = 5'd0;
    tick();
    total++; if (bus_if.rd_valid !== 1'b0) begin bad++; $display("FAIL wr_idle_valid: got %0b want 0", bus_if.rd_valid); end
    total++; if (bus_if.rd_data_a !== 64'hDEADBEEF_00000001) begin bad++; $display("FAIL wr_hold_a: got %h want deadbeef00000001", bus_if.rd_data_a); end
  endtask

  task automatic test_r0_drop();
    do_write(5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    total++; if (bus_if.wr_drop !== 1'b1) begin bad++; $display("FAIL drop_pulse: got %0b want 1", bus_if.wr_drop); end
    total++; if (bus_if.wr_count !== 16'd1) begin bad++; $display("FAIL drop_count: got %0d want 1", bus_if.wr_count); end
    do_read(5'd0, 5'd0);
    total++; if (bus_if.wr_drop !== 1'b0) begin bad++; $display("FAIL drop_one_cycle: got %0b want 0", bus_if.wr_drop); end
    total++; if (bus_if.rd_data_a !== 64'd0) begin bad++; $display("FAIL drop_read_r0: got %h want 0", bus_if.rd_data_a); end
  endtask

  task automatic test_bypass();
    logic [63:0] exp_a;
`ifdef REGFILE_WR_BYPASS_EN
    exp_a = 64'h22;
`else
    exp_a = 64'h11;
`endif
    do_write(5'd7, 64'h11);
    bus_if.wr_en     = 1'b1;
    bus_if.wr_addr   = 5'd7;
    bus_if.wr_data   = 64'h22;
    bus_if.rd_en     = 1'b1;
    bus_if.rd_addr_a = 5'd7;
    bus_if.rd_addr_b = 5'd5;
    tick();
    bus_if.wr_en = 1'b0;
    bus_if.rd_en = 1'b0;
    total++; if (bus_if.rd_data_a !== exp_a) begin bad++; $display("FAIL byp_same_cycle: got %h want %h", bus_if.rd_data_a, exp_a); end
    total++; if (bus_if.rd_data_b !== 64'hDEADBEEF_00000001) begin bad++; $display("FAIL byp_other_port: got %h want deadbeef00000001", bus_if.rd_data_b); end
    total++; if (bus_if.wr_count !== 16'd3) begin bad++; $display("FAIL byp_count: got %0d want 3", bus_if.wr_count); end
    do_read(5'd7, 5'd7);
    total++; if (bus_if.rd_data_a !== 64'h22) begin bad++; $display("FAIL byp_next_a: got %h want 22", bus_if.rd_data_a); end
    total++; if (bus_if.rd_data_b !== 64'h22) begin bad++; $display("FAIL byp_next_b: got %h want 22", bus_if.rd_data_b); end
    bus_if.wr_en     = 1'b1;
    bus_if.wr_addr   = 5'd0;
    bus_if.wr_data   = 64'hFFFF_FFFF_FFFF_FFFF;
    bus_if.rd_en     = 1'b1;
    bus_if.rd_addr_a = 5'd0;
    bus_if.rd_addr_b = 5'd7;
    tick();
    bus_if.wr_en = 1'b0;
    bus_if.rd_en = 1'b0;
    total++; if (bus_if.rd_data_a !== 64'd0) begin bad++; $display("FAIL byp_r0: got %h want 0", bus_if.rd_data_a); end
    total++; if (bus_if.wr_drop !== 1'b1) begin bad++; $display("FAIL byp_r0_drop: got %0b want 1", bus_if.wr_drop); end
  endtask

  task automatic test_clear();
    int cycles = 0;
    for (int i = 1; i < 32; i++) do_write(5'(i), 64'(i));
    bus_if.clr_req = 1'b1;
    bus_if.wr_en   = 1'b1;
    bus_if.wr_addr = 5'd4;
    bus_if.wr_data = 64'h444;
    tick();
    bus_if.clr_req = 1'b0;
    bus_if.wr_addr = 5'd9;
    bus_if.wr_data = 64'h999;
    bus_if.rd_en   = 1'b1;
    bus_if.rd_addr_a = 5'd9;
    while (bus_if.busy === 1'b1 && cycles < 100) begin
      if (bus_if.rd_valid !== 1'b0 || bus_if.wr_drop !== 1'b0) begin
        total++; bad++;
        $display("FAIL clr_ignore: cycle %0d rd_valid=%0b wr_drop=%0b want 0/0", cycles, bus_if.rd_valid, bus_if.wr_drop);
      end
      cycles++;
      tick();
    end
    bus_if.wr_en = 1'b0;
    bus_if.rd_en = 1'b0;
    total++; if (cycles !== 32) begin bad++; $display("FAIL clr_busy_cycles: got %0d want 32", cycles); end
    total++; if (bus_if.wr_count !== 16'd35) begin bad++; $display("FAIL clr_count: got %0d want 35", bus_if.wr_count); end
    for (int i = 1; i < 32; i++) begin
      do_read(5'(i), 5'(i));
      total++;
      if (bus_if.rd_data_a !== 64'd0 || bus_if.rd_data_b !== 64'd0) begin
        bad++; $display("FAIL clr_reg%0d: got a=%h b=%h want 0", i, bus_if.rd_data_a, bus_if.rd_data_b);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    do_write(5'd12, 64'hABC);
    do_write(5'd20, 64'h20);
    do_read(5'd12, 5'd20);
    total++; if (bus_if.rd_data_a !== 64'hABC) begin bad++; $display("FAIL mid_pre_read: got %h want abc", bus_if.rd_data_a); end
    bus_if.clr_req = 1'b1;
    tick();
    bus_if.clr_req = 1'b0;
    repeat (9) tick();
    total++; if (bus_if.busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %0b want 1", bus_if.busy); end
    rst_n = 1'b0;
    #1;
    total++; if (bus_if.busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %0b want 0", bus_if.busy); end
    total++; if (bus_if.wr_count !== 16'd0) begin bad++; $display("FAIL mid_rst_count: got %0d want 0", bus_if.wr_count); end
    total++; if (bus_if.rd_data_a !== 64'd0) begin bad++; $display("FAIL mid_rst_rd_a: got %h want 0", bus_if.rd_data_a); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    do_read(5'd20, 5'd12);
    total++; if (bus_if.rd_valid !== 1'b1) begin bad++; $display("FAIL mid_post_valid: got %0b want 1", bus_if.rd_valid); end
    total++; if (bus_if.rd_data_a !== 64'd0) begin bad++; $display("FAIL mid_post_r20: got %h want 0", bus_if.rd_data_a); end
    total++; if (bus_if.rd_data_b !== 64'd0) begin bad++; $display("FAIL mid_post_r12: got %h want 0", bus_if.rd_data_b); end
    total++; if (bus_if.wr_count !== 16'd0) begin bad++; $display("FAIL mid_post_count: got %0d want 0", bus_if.wr_count); end
  endtask

  task automatic test_count_wrap();
    bus_if.wr_en   = 1'b1;
    bus_if.wr_addr = 5'd2;
    for (int i = 0; i < 65535; i++) begin
      bus_if.wr_data = 64'(i);
      tick();
    end
    bus_if.wr_en = 1'b0;
    total++; if (bus_if.wr_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_max: got %h want ffff", bus_if.wr_count); end
    do_write(5'd2, 64'd65535);
    total++; if (bus_if.wr_count !== 16'd0) begin bad++; $display("FAIL wrap_zero: got %h want 0", bus_if.wr_count); end
    do_read(5'd2, 5'd0);
    total++; if (bus_if.rd_data_a !== 64'd65535) begin bad++; $display("FAIL wrap_data: got %h want ffff", bus_if.rd_data_a); end
  endtask

  initial begin
    bus_if.wr_en     = 1'b0;
    bus_if.wr_addr   = '0;
    bus_if.wr_data   = '0;
    bus_if.rd_en     = 1'b0;
    bus_if.rd_addr_a = '0;
    bus_if.rd_addr_b = '0;
    bus_if.clr_req   = 1'b0;
    test_reset();
    test_write();
    test_r0_drop();
    test_bypass();
    test_clear();
    test_reset_mid_clear();
    test_count_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
